// File: rtl/ps2_key_display.sv
// PS/2 keyboard front end: pops scancodes from the receiver FIFO, tracks modifiers,
// the held key and a press counter, and drives a seven-segment display.
module ps2_key_display #(
    parameter int NUM_DIGITS     = 8,
    parameter int CNT_W          = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ready,
    input  logic                    overflow,
    input  logic [7:0]              data,
    output logic                    nextdata_n,
    output logic                    ctrl,
    output logic                    shift,
    output logic                    alt,
    output logic                    caps,
    output logic                    key_held,
    output logic [CNT_W-1:0]        press_cnt,
    output logic [8*NUM_DIGITS-1:0] seg
);
    localparam int CNT_DIG = (CNT_W + 3) / 4;
    localparam int CNT_PAD = 4 * CNT_DIG;

    typedef enum logic {IDLE, ACK} state_t;

    state_t             state_reg;
    logic               ext_reg;
    logic               brk_reg;
    logic [7:0]         held_code_reg;
    logic               brk_eff;
    logic               new_press;
    logic [7:0]         ascii;
    logic [CNT_PAD-1:0] cnt_pad;

    // An overflow at the same edge discards any pending prefix before the byte is parsed.
    assign brk_eff   = brk_reg && !overflow;
    assign new_press = !(key_held && (data == held_code_reg));
    assign cnt_pad   = CNT_PAD'(press_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            nextdata_n    <= 1'b1;
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            held_code_reg <= 8'h00;
            ctrl          <= 1'b0;
            shift         <= 1'b0;
            alt           <= 1'b0;
            caps          <= 1'b0;
            key_held      <= 1'b0;
            press_cnt     <= '0;
        end else begin
            if (overflow) begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (ready) begin
                        nextdata_n <= 1'b0;
                        state_reg  <= ACK;
                        if (data == 8'hF0) begin
                            brk_reg <= 1'b1;
                        end else if (data == 8'hE0) begin
                            ext_reg <= 1'b1;
                        end else begin
                            ext_reg <= 1'b0;
                            brk_reg <= 1'b0;
                            if (!brk_eff) begin
                                if (new_press) begin
                                    press_cnt     <= press_cnt + 1'b1;
                                    held_code_reg <= data;
                                    key_held      <= 1'b1;
                                    if (data == 8'h58) caps <= ~caps;
                                end
                                if (data == 8'h14) ctrl <= 1'b1;
                                if (data == 8'h12 || data == 8'h59) shift <= 1'b1;
                                if (data == 8'h11) alt <= 1'b1;
                            end else begin
                                if (data == 8'h14) ctrl <= 1'b0;
                                if (data == 8'h12 || data == 8'h59) shift <= 1'b0;
                                if (data == 8'h11) alt <= 1'b0;
                                if (data == held_code_reg) key_held <= 1'b0;
                            end
                        end
                    end
                end
                ACK: begin
                    nextdata_n <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
            8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
            8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
            8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
            8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
            8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
            8'h35: ch = "y";  8'h1A: ch = "z";
            8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
            8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
            8'h3E: ch = "8";  8'h46: ch = "9";
            default: ch = 8'h00;
        endcase
        if (upper && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
        return ch;
    endfunction

    assign ascii = ascii_of(held_code_reg, shift ^ caps);

    // Glyph bits are a..g in active-high form; polarity is applied last so dp stays dark.
    function automatic logic [7:0] digit_seg(input logic [3:0] nib, input logic lit);
        logic [6:0] g;
        logic [7:0] raw;
        case (nib)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        raw = lit ? {1'b0, g} : 8'h00;
        return SEG_ACTIVE_LOW ? ~raw : raw;
    endfunction

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        if (gi < 2) begin : g_code
            assign seg[8*gi +: 8] = digit_seg(held_code_reg[4*gi +: 4], key_held);
        end else if (gi < 4) begin : g_ascii
            assign seg[8*gi +: 8] = digit_seg(ascii[4*(gi-2) +: 4], key_held);
        end else if (gi < 4 + CNT_DIG) begin : g_cnt
            assign seg[8*gi +: 8] = digit_seg(cnt_pad[4*(gi-4) +: 4], 1'b1);
        end else begin : g_blank
            assign seg[8*gi +: 8] = digit_seg(4'h0, 1'b0);
        end
    end

endmodule

// File: tb/tb_ps2_key_display.sv
// Self-checking bench for ps2_key_display: directed scenarios plus random byte streams
// compared against a key-state model of the keyboard.
module tb_ps2_key_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic        overflow = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        nextdata_n, ctrl, shift, alt, caps, key_held;
    logic [7:0]  press_cnt;
    logic [63:0] seg;

    int total = 0;
    int bad = 0;

    // Model of the keyboard state
    logic       m_ctrl, m_shift, m_alt, m_caps, m_held, m_ext, m_brk;
    logic [7:0] m_code, m_cnt;

    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
        7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [7:0] POOL [12] = '{8'hF0, 8'hE0, 8'h1C, 8'h32, 8'h12, 8'h59, 8'h14,
        8'h11, 8'h58, 8'h45, 8'h1C, 8'hF0};

    ps2_key_display #(.NUM_DIGITS(8), .CNT_W(8), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .ready(ready), .overflow(overflow), .data(data),
        .nextdata_n(nextdata_n), .ctrl(ctrl), .shift(shift), .alt(alt), .caps(caps),
        .key_held(key_held), .press_cnt(press_cnt), .seg(seg)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        {m_ctrl, m_shift, m_alt, m_caps, m_held, m_ext, m_brk} = '0;
        m_code = 8'h00;
        m_cnt  = 8'h00;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic ov);
        if (ov) begin m_ext = 1'b0; m_brk = 1'b0; end
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_brk) begin
                if (!m_held || b != m_code) begin
                    m_cnt  = m_cnt + 8'd1;
                    m_code = b;
                    m_held = 1'b1;
                    if (b == 8'h58) m_caps = !m_caps;
                end
                if (b == 8'h14) m_ctrl = 1'b1;
                if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
                if (b == 8'h11) m_alt = 1'b1;
            end else begin
                if (b == 8'h14) m_ctrl = 1'b0;
                if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
                if (b == 8'h11) m_alt = 1'b0;
                if (b == m_code) m_held = 1'b0;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic logic [7:0] m_ascii(input logic [7:0] code, input logic upper);
        for (int i = 0; i < 26; i++)
            if (code == LETTERS[i]) return 8'((upper ? 8'h41 : 8'h61) + i);
        for (int i = 0; i < 10; i++)
            if (code == DIGITS[i]) return 8'(8'h30 + i);
        return 8'h00;
    endfunction

    function automatic logic [7:0] dig(input logic [3:0] n);
        return ~{1'b0, GLYPH[n]};
    endfunction

    function automatic logic [63:0] exp_seg();
        logic [63:0] s;
        logic [7:0]  a;
        a = m_ascii(m_code, m_shift ^ m_caps);
        s = {8{8'hFF}};
        if (m_held) begin
            s[7:0]   = dig(m_code[3:0]);
            s[15:8]  = dig(m_code[7:4]);
            s[23:16] = dig(a[3:0]);
            s[31:24] = dig(a[7:4]);
        end
        s[39:32] = dig(m_cnt[3:0]);
        s[47:40] = dig(m_cnt[7:4]);
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input logic nd_exp);
        check({tag, "_nd"}, 64'(nextdata_n), 64'(nd_exp));
        check({tag, "_flags"}, 64'({ctrl, shift, alt, caps, key_held}),
              64'({m_ctrl, m_shift, m_alt, m_caps, m_held}));
        check({tag, "_cnt"}, 64'(press_cnt), 64'(m_cnt));
        check({tag, "_seg"}, seg, exp_seg());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ready = 1'b0; overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset", 1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic ov);
        @(negedge clk);
        ready = 1'b1; data = b; overflow = ov;
        @(posedge clk);
        #1;
        ready = 1'b0; overflow = 1'b0;
        model_byte(b, ov);
        check_all("byte", 1'b0);
        $display("byte %h ov=%0d cnt=%h held=%0d code=%h", b, ov, press_cnt, key_held, m_code);
        @(posedge clk);
        #1;
        check("ack_release", 64'(nextdata_n), 64'd1);
    endtask

    task automatic ovf_pulse();
        @(negedge clk);
        overflow = 1'b1;
        @(posedge clk);
        #1;
        overflow = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0;
        check_all("ovf", 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        model_reset();
        do_reset();

        // Make, then break of 'a'
        send(8'h1C, 1'b0);
        check("t1_ascii", seg[31:16], {dig(4'h6), dig(4'h1)});
        check("t1_cnt", 64'(press_cnt), 64'd1);
        send(8'hF0, 1'b0);
        send(8'h1C, 1'b0);
        check("t1_blank", seg[31:0], 32'hFFFF_FFFF);

        // Typematic repeats, then a new key
        send(8'h1C, 1'b0); send(8'h1C, 1'b0); send(8'h1C, 1'b0);
        check("t2_typematic", 64'(press_cnt), 64'd2);
        send(8'h32, 1'b0);
        check("t2_new", 64'(press_cnt), 64'd3);

        // Shift and caps lock interplay
        send(8'h12, 1'b0); send(8'h1C, 1'b0);
        check("t3_upper", seg[31:16], {dig(4'h4), dig(4'h1)});
        send(8'h58, 1'b0); send(8'hF0, 1'b0); send(8'h58, 1'b0);
        send(8'h1C, 1'b0);
        check("t3_caps_shift", seg[31:16], {dig(4'h6), dig(4'h1)});
        send(8'hF0, 1'b0); send(8'h12, 1'b0);

        // Extended ctrl and prefix resync on overflow
        send(8'hE0, 1'b0); send(8'h14, 1'b0);
        check("t4_ctrl_on", 64'(ctrl), 64'd1);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h14, 1'b0);
        check("t4_ctrl_off", 64'(ctrl), 64'd0);
        send(8'hE0, 1'b0); ovf_pulse(); send(8'h14, 1'b0);
        send(8'hF0, 1'b0); ovf_pulse(); send(8'h32, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b1);

        // Random byte stream with occasional overflow
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
            else b = POOL[$urandom_range(0, 11)];
            send(b, ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 19) == 0) ovf_pulse();
        end

        // Counter wrap after 257 distinct presses
        do_reset();
        for (int i = 0; i < 257; i++) begin
            b = (i % 2 == 0) ? 8'h1C : 8'h32;
            send(b, 1'b0); send(8'hF0, 1'b0); send(b, 1'b0);
        end
        check("t5_wrap_cnt", 64'(press_cnt), 64'h01);
        check("t5_wrap_seg", seg[47:32], {dig(4'h0), dig(4'h1)});

        // ready held high: one pop every second cycle, then reset during ACK
        @(negedge clk);
        ready = 1'b1; data = 8'h1C;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (k % 2 == 0) model_byte(8'h1C, 1'b0);
            check_all("t6_stream", (k % 2 == 0) ? 1'b0 : 1'b1);
            $display("stream cycle %0d nextdata_n=%0d", k, nextdata_n);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_all("t6_rst_in_ack", 1'b1);
        @(posedge clk);
        #1;
        check_all("t6_rst_ready", 1'b1);
        @(negedge clk);
        rst = 1'b0; ready = 1'b0;
        send(8'h45, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
